decode_stage: RTL and testbench

Registered, parametrised instruction decode stage with valid/ready handshakes on both sides and one output pipeline register. It sits between the fetch/instruction-buffer stage and register read/execute. It classifies each 32-bit instruction as R, I or J type, extracts all fields, and extends the immediate, target and shift amount to XLEN. It also detects load-use hazards and inserts exactly one bubble per hazard, and it counts the bubbles it inserts.

---
 rtl/decode_stage.sv | 144 ++++++++++++++
 tb/tb_decode_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered instruction decode stage: R/I/J classification, field
// extraction, XLEN extension and load-use bubble insertion with a counter.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid/in_ready   upstream handshake, instruction is the payload
//   flush               synchronous kill of the bundle and load tracking
//   out_valid/out_ready downstream handshake for the registered bundle
//   R, I, J             one-hot type class
//   op, funct           opcode and function fields
//   rs, rt, rd, dest    register fields; dest = rd (R), rt (I), 0 (J)
//   shamt, imm, tar_add shift amount, immediate, jump target at XLEN
//   bubble_cnt          saturating count of inserted bubbles
module decode_stage #(
   parameter int          XLEN      = 32,
   parameter logic [5:0]  J_OP_A    = 6'b000001,
   parameter logic [5:0]  J_OP_B    = 6'b000010,
   parameter logic [5:0]  ZEXT_OP_A = 6'b000101,
   parameter logic [5:0]  ZEXT_OP_B = 6'b000110,
   parameter logic [5:0]  LOAD_OP   = 6'b100011,
   parameter logic [5:0]  STORE_OP  = 6'b101011,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             R,
   output logic             I,
   output logic             J,
   output logic [5:0]       op,
   output logic [5:0]       funct,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       dest,
   output logic [XLEN-1:0]  shamt,
   output logic [XLEN-1:0]  imm,
   output logic [XLEN-1:0]  tar_add,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic [5:0]      d_op;
   logic [4:0]      d_rs;
   logic [4:0]      d_rt;
   logic [4:0]      d_rd;
   logic            d_r;
   logic            d_j;
   logic            d_zext;
   logic [4:0]      d_dest;
   logic [XLEN-1:0] d_imm;

   logic            ld_pend;
   logic [4:0]      ld_rt;
   logic            free;
   logic            haz;
   logic            accept;
   logic            bubble;

   assign d_op   = instruction[31:26];
   assign d_rs   = instruction[25:21];
   assign d_rt   = instruction[20:16];
   assign d_rd   = instruction[15:11];
   assign d_r    = (d_op == 6'd0);
   assign d_j    = (d_op == J_OP_A) || (d_op == J_OP_B);
   assign d_zext = (d_op == ZEXT_OP_A) || (d_op == ZEXT_OP_B);

   always_comb begin
      d_dest = d_rt;
      unique case (1'b1)
         d_r:     d_dest = d_rd;
         d_j:     d_dest = 5'd0;
         default: d_dest = d_rt;
      endcase
   end

   assign d_imm = d_zext
      ? {{(XLEN-16){1'b0}}, instruction[15:0]}
      : {{(XLEN-16){instruction[15]}}, instruction[15:0]};

   // Stores and R-types read rt; everything reads rs.
   assign free = !out_valid || out_ready;
   assign haz  = ld_pend && in_valid &&
                 ((d_rs == ld_rt) ||
                  ((d_rt == ld_rt) && (d_r || (d_op == STORE_OP))));

   assign in_ready = free && !flush && !haz;
   assign accept   = in_valid && in_ready;
   assign bubble   = free && !flush && haz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         ld_pend    <= 1'b0;
         ld_rt      <= '0;
         bubble_cnt <= '0;
         R          <= 1'b0;
         I          <= 1'b0;
         J          <= 1'b0;
         op         <= '0;
         funct      <= '0;
         rs         <= '0;
         rt         <= '0;
         rd         <= '0;
         dest       <= '0;
         shamt      <= '0;
         imm        <= '0;
         tar_add    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         ld_pend   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         R         <= d_r;
         I         <= !d_r && !d_j;
         J         <= d_j;
         op        <= d_op;
         funct     <= instruction[5:0];
         rs        <= d_rs;
         rt        <= d_rt;
         rd        <= d_rd;
         dest      <= d_dest;
         shamt     <= {{(XLEN-5){1'b0}}, instruction[10:6]};
         imm       <= d_imm;
         tar_add   <= {{(XLEN-26){1'b0}}, instruction[25:0]};
         // A load to r0 can never create a dependency.
         ld_pend   <= (d_op == LOAD_OP) && (d_rt != 5'd0);
         if ((d_op == LOAD_OP) && (d_rt != 5'd0))
            ld_rt <= d_rt;
      end else if (bubble) begin
         out_valid <= 1'b0;
         ld_pend   <= 1'b0;
         if (bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else if (free) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a
// randomized stream compared against a behavioural reference model.
module tb_decode_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instruction;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic             R, I, J;
   logic [5:0]       op, funct;
   logic [4:0]       rs, rt, rd, dest;
   logic [XLEN-1:0]  shamt, imm, tar_add;
   logic [CNT_W-1:0] bubble_cnt;
   logic [130:0]     fields;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .R(R), .I(I), .J(J),
      .op(op), .funct(funct),
      .rs(rs), .rt(rt), .rd(rd), .dest(dest),
      .shamt(shamt), .imm(imm), .tar_add(tar_add),
      .bubble_cnt(bubble_cnt)
   );

   assign fields = {R, I, J, op, funct, rs, rt, rd, dest,
                    shamt, imm, tar_add};

   // Reference decode built straight from the field rules.
   function automatic logic [130:0] model(input logic [31:0] ins);
      logic [5:0]  o;
      logic        r, j, i;
      logic [4:0]  d;
      logic [31:0] im;
      int          v;
      o = ins[31:26];
      r = (o == 6'd0);
      j = (o == 6'd1) || (o == 6'd2);
      i = !r && !j;
      if (r) d = ins[15:11];
      else if (j) d = 5'd0;
      else d = ins[20:16];
      v = int'(ins[15:0]);
      if (o != 6'd5 && o != 6'd6 && v >= 32768) v = v - 65536;
      im = 32'(v);
      return {r, i, j, o, ins[5:0], ins[25:21], ins[20:16],
              ins[15:11], d, 32'(ins[10:6]), im, 32'(ins[25:0])};
   endfunction

   function automatic int sat_inc(input int c);
      return (c >= 15) ? 15 : c + 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      out_ready = 1'b1; instruction = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, fields, bubble_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b f=%h c=%h want 0",
                  out_valid, fields, bubble_cnt);
      end
      rst = 1'b0;
      exp_cnt = 0;
      #2;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
      tick();
   endtask

   task automatic test_rtype();
      instruction = 32'h014B4820; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, R, rs, rt, rd, dest, shamt, funct} !==
          {1'b1, 1'b1, 5'd10, 5'd11, 5'd9, 5'd9, 32'd0, 6'h20}) begin
         failures++;
         $display("FAIL rtype_fields got v=%b R=%b rs=%0d rt=%0d rd=%0d d=%0d sh=%0d f=%h",
                  out_valid, R, rs, rt, rd, dest, shamt, funct);
      end
      checks++;
      if (fields !== model(32'h014B4820)) begin
         failures++;
         $display("FAIL rtype_model got=%h want=%h",
                  fields, model(32'h014B4820));
      end
   endtask

   task automatic test_imm();
      instruction = 32'h2128FFFC; in_valid = 1'b1;
      tick();
      checks++;
      if ({imm, I, dest} !== {32'hFFFFFFFC, 1'b1, 5'd8}) begin
         failures++;
         $display("FAIL imm_sext got imm=%h I=%b d=%0d want FFFFFFFC 1 8",
                  imm, I, dest);
      end
      instruction = 32'h1928FFFC;
      tick();
      in_valid = 1'b0;
      checks++;
      if (imm !== 32'h0000FFFC) begin
         failures++;
         $display("FAIL imm_zext got=%h want=0000FFFC", imm);
      end
   endtask

   task automatic test_jtype();
      instruction = 32'h0BFFFFFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({J, R, I, tar_add, dest} !==
          {1'b1, 1'b0, 1'b0, 32'h03FFFFFF, 5'd0}) begin
         failures++;
         $display("FAIL jtype got J=%b tar=%h d=%0d want 1 03FFFFFF 0",
                  J, tar_add, dest);
      end
   endtask

   task automatic test_load_use();
      instruction = 32'h8D280000; in_valid = 1'b1;
      tick();
      instruction = 32'h01094820;
      #2;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL lu_stall got in_ready=%b want=0", in_ready);
      end
      tick();
      exp_cnt = sat_inc(exp_cnt);
      checks++;
      if ({out_valid, bubble_cnt} !== {1'b0, 4'(exp_cnt)}) begin
         failures++;
         $display("FAIL lu_bubble got v=%b cnt=%0d want 0 %0d",
                  out_valid, bubble_cnt, exp_cnt);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, fields} !== {1'b1, model(32'h01094820)}) begin
         failures++;
         $display("FAIL lu_dep got v=%b f=%h", out_valid, fields);
      end
   endtask

   task automatic test_no_hazard(input logic [31:0] ld,
                                 input logic [31:0] nxt);
      instruction = ld; in_valid = 1'b1;
      tick();
      instruction = nxt;
      #2;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL nohaz_ready ld=%h got=%b want=1", ld, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, fields, bubble_cnt} !==
          {1'b1, model(nxt), 4'(exp_cnt)}) begin
         failures++;
         $display("FAIL nohaz_out ld=%h got v=%b cnt=%0d want cnt=%0d",
                  ld, out_valid, bubble_cnt, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      instruction = 32'h2128FFFC; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      instruction = 32'h014B4820;
      for (int k = 0; k < 3; k++) begin
         #2;
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready cyc=%0d got=%b want=0", k, in_ready);
         end
         tick();
         checks++;
         if ({out_valid, fields} !== {1'b1, model(32'h2128FFFC)}) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got v=%b f=%h",
                     k, out_valid, fields);
         end
      end
      out_ready = 1'b1;
      #2;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got=%b want=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, fields} !== {1'b1, model(32'h014B4820)}) begin
         failures++;
         $display("FAIL bp_next got v=%b f=%h", out_valid, fields);
      end
   endtask

   task automatic test_flush();
      instruction = 32'h8D280000; in_valid = 1'b1;
      tick();
      flush = 1'b1;
      instruction = 32'h01094820;
      #2;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_ready got=%b want=0", in_ready);
      end
      tick();
      flush = 1'b0;
      checks++;
      if ({out_valid, fields} !== {1'b0, model(32'h8D280000)}) begin
         failures++;
         $display("FAIL flush_kill got v=%b f=%h", out_valid, fields);
      end
      #2;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_dep_ready got=%b want=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, fields, bubble_cnt} !==
          {1'b1, model(32'h01094820), 4'(exp_cnt)}) begin
         failures++;
         $display("FAIL flush_dep got v=%b cnt=%0d want cnt=%0d",
                  out_valid, bubble_cnt, exp_cnt);
      end
   endtask

   task automatic test_async_reset();
      instruction = 32'h8D280000; in_valid = 1'b1;
      tick();
      instruction = 32'h01094820;
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, fields, bubble_cnt} !== '0) begin
         failures++;
         $display("FAIL async_rst got v=%b f=%h c=%h want 0",
                  out_valid, fields, bubble_cnt);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      exp_cnt = 0;
      tick();
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 18; k++) begin
         instruction = 32'h8D280000; in_valid = 1'b1;
         tick();
         instruction = 32'h01094820;
         tick();
         exp_cnt = sat_inc(exp_cnt);
         checks++;
         if (bubble_cnt !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL sat_step k=%0d got=%0d want=%0d",
                     k, bubble_cnt, exp_cnt);
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (bubble_cnt !== 4'hF) begin
         failures++;
         $display("FAIL sat_final got=%h want=F", bubble_cnt);
      end
   endtask

   task automatic test_random();
      logic [5:0]   ops [8];
      logic [31:0]  ins;
      logic [130:0] m_fields;
      logic         m_valid, slot, dep, exp_ready;
      logic [5:0]   o;
      logic [4:0]   s, t;
      int           pend_rt, cnt;
      ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd2, 6'd6, 6'd5, 6'd1};
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      #3;
      rst = 1'b0;
      tick();
      m_valid = 1'b0; m_fields = '0; pend_rt = 0; cnt = 0;
      for (int n = 0; n < 500; n++) begin
         ins = $urandom;
         ins[31:26] = ops[$urandom_range(0, 7)];
         ins[25:21] = 5'($urandom_range(0, 3));
         ins[20:16] = 5'($urandom_range(0, 3));
         instruction = ins;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         o = ins[31:26]; s = ins[25:21]; t = ins[20:16];
         slot = !m_valid || out_ready;
         dep  = (pend_rt != 0) && in_valid &&
                (int'(s) == pend_rt ||
                 (int'(t) == pend_rt && (o == 6'd0 || o == 6'd43)));
         exp_ready = slot && !flush && !dep;
         #2;
         checks++;
         if (in_ready !== exp_ready) begin
            failures++;
            $display("FAIL rnd_ready n=%0d got=%b want=%b",
                     n, in_ready, exp_ready);
         end
         tick();
         if (flush) begin
            m_valid = 1'b0; pend_rt = 0;
         end else if (slot) begin
            if (in_valid && exp_ready) begin
               m_valid = 1'b1;
               m_fields = model(ins);
               pend_rt = (o == 6'd35) ? int'(t) : 0;
            end else if (dep) begin
               m_valid = 1'b0; pend_rt = 0;
               cnt = sat_inc(cnt);
            end else begin
               m_valid = 1'b0;
            end
         end
         checks++;
         if ({out_valid, fields, bubble_cnt} !==
             {m_valid, m_fields, 4'(cnt)}) begin
            failures++;
            $display("FAIL rnd_out n=%0d got v=%b c=%0d f=%h want v=%b c=%0d f=%h",
                     n, out_valid, bubble_cnt, fields,
                     m_valid, cnt, m_fields);
         end
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_imm();
      test_jtype();
      test_load_use();
      test_no_hazard(32'h8D280000, 32'h01294820);
      test_no_hazard(32'h8D200000, 32'h00004820);
      test_backpressure();
      test_flush();
      test_async_reset();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
